apbuart_apb_master: RTL and testbench

Two-port APB master that arbitrates register-access requests from two on-chip requesters (port 0: CPU bridge, port 1: DMA/config sequencer) and drives single APB transfers to the UART register block. Round-robin arbitration, one transfer in flight, pready wait-state support, and a wait-state timeout that converts a hung slave into an error response. All generated APB traffic satisfies the team's APB UART protocol properties:
- psel rise → penable rise next cycle
- penable falls with psel
- pwrite stable across the transfer

---
 rtl/apbuart_apb_master.sv | 149 ++++++++++++++
 tb/tb_apbuart_apb_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apbuart_apb_master.sv
// Two-port APB master for the UART register block.
// Round-robin arbitration between two requesters, one APB transfer in flight,
// pready wait states, and a wait-state timeout that turns a hung slave into an error.
//
// Handshake: reqN_ready is a combinational acknowledge that is only raised in IDLE,
// for at most one port. A request transfers when reqN_valid && reqN_ready. rspN_valid
// is a one-cycle pulse with no backpressure, and rdata/err are qualified by it.
module apbuart_apb_master #(
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_write,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    output logic          rsp0_err,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_write,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic          rsp1_err,
    output logic          psel_o,
    output logic          penable_o,
    output logic          pwrite_o,
    output logic [AW-1:0] paddr_o,
    output logic [DW-1:0] pwdata_o,
    input  logic [DW-1:0] prdata_i,
    input  logic          pready_i,
    input  logic          pslverr_i
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t         state;
    state_t         state_nxt;
    logic           last_grant;  // port granted most recently
    logic           port;        // port owning the transfer in flight
    logic [CW-1:0]  wait_cnt;
    logic [DW-1:0]  rdata_q;
    logic           err_q;
    logic           grant0;
    logic           grant1;
    logic           capture;
    logic           abort;

    // State register; reset drops psel/penable immediately since they decode from state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, arbitration and completion decisions.
    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    // On a tie the port that did not win last time goes first.
                    grant1    = req1_valid && (!req0_valid || !last_grant);
                    grant0    = !grant1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (pready_i) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th consecutive low-pready cycle.
                    abort     = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch, grant history, wait counter and response capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            port       <= 1'b0;
            pwrite_o   <= 1'b0;
            paddr_o    <= '0;
            pwdata_o   <= '0;
            wait_cnt   <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (grant0 || grant1) begin
                port       <= grant1;
                last_grant <= grant1;
                pwrite_o   <= grant1 ? req1_write : req0_write;
                paddr_o    <= grant1 ? req1_addr  : req0_addr;
                pwdata_o   <= grant1 ? req1_wdata : req0_wdata;
                wait_cnt   <= '0;
            end else if (state == ACCESS && !pready_i) begin
                wait_cnt <= wait_cnt + CW'(1);
            end

            if (capture) begin
                // Read data is only meaningful on a clean read.
                rdata_q <= (!pwrite_o && !pslverr_i) ? prdata_i : '0;
                err_q   <= pslverr_i;
            end else if (abort) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign psel_o     = (state == SETUP) || (state == ACCESS);
    assign penable_o  = (state == ACCESS);
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = (state == RESP) && !port;
    assign rsp1_valid = (state == RESP) && port;
    assign rsp0_rdata = rsp0_valid ? rdata_q : '0;
    assign rsp1_rdata = rsp1_valid ? rdata_q : '0;
    assign rsp0_err   = rsp0_valid && err_q;
    assign rsp1_err   = rsp1_valid && err_q;

endmodule

// File: tb/tb_apbuart_apb_master.sv
// Directed bench for apbuart_apb_master: inputs change 1 ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_apbuart_apb_master;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req0_write;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          rsp0_valid, rsp0_err;
    logic [DW-1:0] rsp0_rdata;
    logic          req1_valid, req1_ready, req1_write;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp1_valid, rsp1_err;
    logic [DW-1:0] rsp1_rdata;
    logic          psel_o, penable_o, pwrite_o;
    logic [AW-1:0] paddr_o;
    logic [DW-1:0] pwdata_o;
    logic [DW-1:0] prdata_i;
    logic          pready_i, pslverr_i;

    int n_vec = 0;
    int n_bad = 0;

    apbuart_apb_master #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
        prdata_i = '0; pready_i = 1'b1; pslverr_i = 1'b0;

        // Reset state
        drive(); drive();
        look();
        chk("rst_psel", psel_o, 0);
        chk("rst_penable", penable_o, 0);
        chk("rst_pwrite", pwrite_o, 0);
        chk("rst_paddr", paddr_o, 0);
        chk("rst_pwdata", pwdata_o, 0);
        chk("rst_rsp0", rsp0_valid, 0);
        chk("rst_rsp1", rsp1_valid, 0);
        chk("rst_rdy0", req0_ready, 0);
        drive(); rst = 1'b0;
        look();

        // Port-0 zero-wait write
        drive();
        req0_valid = 1; req0_write = 1; req0_addr = 8'h04; req0_wdata = 32'h0000_00A5;
        look();
        chk("t1_rdy0", req0_ready, 1);
        chk("t1_rdy1", req1_ready, 0);
        chk("t1_psel_T", psel_o, 0);
        drive(); req0_valid = 0;
        look();
        chk("t1_setup_psel", psel_o, 1);
        chk("t1_setup_pen", penable_o, 0);
        chk("t1_setup_addr", paddr_o, 32'h04);
        chk("t1_setup_wdata", pwdata_o, 32'hA5);
        chk("t1_setup_pwrite", pwrite_o, 1);
        chk("t1_setup_rdy0", req0_ready, 0);
        drive(); look();
        chk("t1_acc_psel", psel_o, 1);
        chk("t1_acc_pen", penable_o, 1);
        chk("t1_acc_addr", paddr_o, 32'h04);
        chk("t1_acc_wdata", pwdata_o, 32'hA5);
        chk("t1_acc_pwrite", pwrite_o, 1);
        drive(); look();
        chk("t1_rsp0", rsp0_valid, 1);
        chk("t1_err0", rsp0_err, 0);
        chk("t1_rsp1", rsp1_valid, 0);
        chk("t1_resp_psel", psel_o, 0);
        chk("t1_resp_pen", penable_o, 0);
        drive(); look();
        chk("t1_rsp0_gone", rsp0_valid, 0);

        // Port-1 read with three wait states
        drive();
        req1_valid = 1; req1_write = 0; req1_addr = 8'h08; pready_i = 0;
        look();
        chk("t2_rdy1", req1_ready, 1);
        chk("t2_rdy0", req0_ready, 0);
        drive(); req1_valid = 0;
        look();
        chk("t2_setup_pen", penable_o, 0);
        chk("t2_setup_addr", paddr_o, 32'h08);
        chk("t2_setup_pwrite", pwrite_o, 0);
        for (int i = 0; i < 3; i++) begin
            drive(); look();
            chk("t2_wait_pen", penable_o, 1);
            chk("t2_wait_norsp", rsp1_valid, 0);
        end
        drive(); pready_i = 1; prdata_i = 32'h0000_0041;
        look();
        chk("t2_last_pen", penable_o, 1);
        drive(); look();
        chk("t2_rsp1", rsp1_valid, 1);
        chk("t2_rdata1", rsp1_rdata, 32'h41);
        chk("t2_err1", rsp1_err, 0);
        chk("t2_rsp0", rsp0_valid, 0);
        drive(); prdata_i = 32'h0000_0077;

        // Both ports continuously valid: six alternating writes, 4 cycles apart
        for (int i = 0; i < 24; i++) begin
            if (i == 0) begin
                req0_valid = 1; req0_write = 1; req0_addr = 8'h20; req0_wdata = 32'h100;
                req1_valid = 1; req1_write = 1; req1_addr = 8'h24; req1_wdata = 32'h200;
            end else begin
                drive();
            end
            if (i == 21) begin
                req0_valid = 0; req1_valid = 0;
            end
            look();
            chk("t3_rdy0", req0_ready, (i % 8 == 0) ? 1 : 0);
            chk("t3_rdy1", req1_ready, (i % 8 == 4) ? 1 : 0);
            chk("t3_one_rdy", req0_ready & req1_ready, 0);
            if (i % 4 == 3) begin
                chk("t3_rsp0", rsp0_valid, (i % 8 == 3) ? 1 : 0);
                chk("t3_rsp1", rsp1_valid, (i % 8 == 7) ? 1 : 0);
                chk("t3_wr_rdata", rsp0_rdata | rsp1_rdata, 0);
            end
            if (i == 1) chk("t3_addr0", paddr_o, 32'h20);
            if (i == 5) chk("t3_addr1", paddr_o, 32'h24);
        end

        // Timeout: pready stuck low
        drive();
        req0_valid = 1; req0_write = 0; req0_addr = 8'h10; pready_i = 0; prdata_i = 32'hDEAD_BEEF;
        look();
        chk("t4_rdy0", req0_ready, 1);
        drive(); req0_valid = 0;
        look();
        chk("t4_setup_pen", penable_o, 0);
        for (int i = 0; i < 16; i++) begin
            drive(); look();
            chk("t4_acc_pen", penable_o, 1);
            chk("t4_acc_norsp", rsp0_valid, 0);
        end
        drive(); look();
        chk("t4_rsp0", rsp0_valid, 1);
        chk("t4_err0", rsp0_err, 1);
        chk("t4_rdata0", rsp0_rdata, 0);
        chk("t4_psel", psel_o, 0);
        // Following request proceeds normally
        drive();
        pready_i = 1; req1_valid = 1; req1_write = 1; req1_addr = 8'h0C; req1_wdata = 32'h12;
        look();
        chk("t4b_rdy1", req1_ready, 1);
        drive(); req1_valid = 0;
        look();
        drive(); look();
        chk("t4b_pen", penable_o, 1);
        drive(); look();
        chk("t4b_rsp1", rsp1_valid, 1);
        chk("t4b_err1", rsp1_err, 0);

        // Slave error on a read
        drive();
        req0_valid = 1; req0_write = 0; req0_addr = 8'h14; pslverr_i = 1; prdata_i = 32'h55;
        look();
        chk("t5_rdy0", req0_ready, 1);
        drive(); req0_valid = 0;
        look();
        drive(); look();
        drive(); look();
        chk("t5_rsp0", rsp0_valid, 1);
        chk("t5_err0", rsp0_err, 1);
        chk("t5_rdata0", rsp0_rdata, 0);
        drive(); pslverr_i = 0;
        look();
        chk("t5_idle_psel", psel_o, 0);
        chk("t5_idle_rsp", rsp0_valid, 0);

        // Reset in the middle of ACCESS
        drive();
        req1_valid = 1; req1_write = 1; req1_addr = 8'h18; req1_wdata = 32'h33; pready_i = 0;
        look();
        chk("t6_rdy1", req1_ready, 1);
        drive(); req1_valid = 0;
        look();
        drive(); look();
        chk("t6_acc_pen", penable_o, 1);
        drive(); rst = 1;
        #1;
        chk("t6_async_psel", psel_o, 0);
        chk("t6_async_pen", penable_o, 0);
        chk("t6_async_paddr", paddr_o, 0);
        look();
        chk("t6_rst_rsp1", rsp1_valid, 0);
        drive(); look();
        chk("t6_rst_rsp1b", rsp1_valid, 0);
        drive();
        rst = 0; pready_i = 1;
        req0_valid = 1; req0_write = 0; req0_addr = 8'h1C;
        req1_valid = 1;
        look();
        chk("t6_tie_rdy0", req0_ready, 1);
        chk("t6_tie_rdy1", req1_ready, 0);
        chk("t6_norsp", rsp1_valid, 0);
        drive(); req0_valid = 0; req1_valid = 0;
        look();
        chk("t6_setup_addr", paddr_o, 32'h1C);
        drive(); drive();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
